// File: rtl/acc4_pkg.sv
// Shared definitions for the 4-bit accumulator controller: opcodes, FSM
// state encoding and datapath widths.
package acc4_pkg;

  localparam int ALU_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

endpackage

// File: rtl/acc4_flags.sv
// Combinational flag generator for the external adder result.
// CF is the raw adder carry-out, so after a subtract (B = ~D, C0 = 1)
// CF = 1 means no borrow occurred.
module acc4_flags
  import acc4_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [ALU_W-1:0] q,
  input  logic             co,
  output logic             cf,
  output logic             vf,
  output logic             zf,
  output logic             nf
);

  // Signed overflow: operands agree in sign but the result does not.
  assign cf = co;
  assign vf = (a[ALU_W-1] == b[ALU_W-1]) && (q[ALU_W-1] != a[ALU_W-1]);
  assign zf = (q == '0);
  assign nf = q[ALU_W-1];

endmodule

// File: rtl/acc4_ctl.sv
// Accumulator controller driving an external 4-bit adder. ADD/SUB hold the
// adder operands stable for SETTLE_CYC cycles before sampling the sum;
// LOAD/CLR complete at the accept edge and allow one op per cycle.
module acc4_ctl
  import acc4_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VLD,
  output logic             IN_RDY,
  input  logic [1:0]       OP,
  input  logic [ALU_W-1:0] D,
  output logic [ALU_W-1:0] A,
  output logic [ALU_W-1:0] B,
  output logic             C0,
  input  logic [ALU_W-1:0] Q,
  input  logic             CO,
  output logic [ALU_W-1:0] ACC,
  output logic             CF,
  output logic             VF,
  output logic             ZF,
  output logic             NF,
  output logic             DONE
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  op_e              op_r;
  logic [ALU_W-1:0] d_r;
  logic [ALU_W-1:0] b;
  logic             c0;
  logic             f_cf, f_vf, f_zf, f_nf;

  assign IN_RDY = (state == ST_IDLE);
  assign A      = ACC;
  assign B      = b;
  assign C0     = c0;

  // Adder operand selection from the latched request only, so B/C0 stay
  // frozen while the adder settles even if D/OP change on the inputs.
  always_comb begin
    // NOTE: defaults first so every path assigns b/c0 and no latch is inferred.
    b  = '0;
    c0 = 1'b0;
    case (op_r)
      OP_ADD:  b = d_r;
      OP_SUB: begin
        b  = ~d_r;
        c0 = 1'b1;
      end
      default: ;
    endcase
  end

  acc4_flags u_flags (
    .a  (ACC),
    .b  (b),
    .q  (Q),
    .co (CO),
    .cf (f_cf),
    .vf (f_vf),
    .zf (f_zf),
    .nf (f_nf)
  );

  // Request FSM, settle counter, accumulator, flags and completion pulse.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_r  <= OP_ADD;
      d_r   <= '0;
      ACC   <= '0;
      CF    <= 1'b0;
      VF    <= 1'b0;
      ZF    <= 1'b1;
      NF    <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (IN_VLD) begin
            op_r <= op_e'(OP);
            d_r  <= D;
            case (op_e'(OP))
              OP_ADD, OP_SUB: begin
                state <= ST_SETTLE;
                cnt   <= SETTLE_LD;
              end
              OP_LOAD: begin
                ACC  <= D;
                CF   <= 1'b0;
                VF   <= 1'b0;
                ZF   <= (D == '0);
                NF   <= D[ALU_W-1];
                DONE <= 1'b1;
              end
              OP_CLR: begin
                ACC  <= '0;
                CF   <= 1'b0;
                VF   <= 1'b0;
                ZF   <= 1'b1;
                NF   <= 1'b0;
                DONE <= 1'b1;
              end
            endcase
          end
        end
        ST_SETTLE: begin
          if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            ACC   <= Q;
            CF    <= f_cf;
            VF    <= f_vf;
            ZF    <= f_zf;
            NF    <= f_nf;
            DONE  <= 1'b1;
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
